// File: rtl/game_pkg.sv
// Shared definitions for the pipe scroller: FSM states, slot count, edge width
// and the wrap-around ROM index increment.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam int NUM_PIPES = 5;
    localparam int Y_W       = 10;
    localparam int SCREEN_W  = 640;
    localparam int IDX_W     = 3;

    // ROM rotation index step; wraps after the last pipe slot.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(NUM_PIPES - 1)) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipe slot: X position and top/bottom edges. Loads from the ROM, moves left
// on each accepted tick and recycles to the far end of the ring when selected.
module pipe_slot
    import game_pkg::*;
#(
    parameter int X_W     = 11,
    parameter int X_INIT  = 680,
    parameter int SPACING = 200,
    parameter int SPEED   = 2,
    parameter int BIRD_X  = 160
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic           move_i,
    input  logic           recycle_i,
    input  logic [Y_W-1:0] rom_top_i,
    input  logic [Y_W-1:0] rom_bot_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] top_o,
    output logic [Y_W-1:0] bot_o,
    output logic           due_o,
    output logic           cross_o
);

    localparam logic [X_W-1:0] X_INIT_C = X_W'(X_INIT);
    localparam logic [X_W-1:0] SPEED_C  = X_W'(SPEED);
    localparam logic [X_W-1:0] RING_C   = X_W'(NUM_PIPES * SPACING);
    localparam logic [X_W-1:0] BIRD_C   = X_W'(BIRD_X);

    logic [X_W-1:0] x_q, x_d, x_moved;
    logic [Y_W-1:0] top_q, top_d, bot_q, bot_d;

    // x_moved may wrap below zero for a due slot; adding the ring length
    // brings it back into range modulo 2^X_W.
    assign x_moved = x_q - SPEED_C;
    assign due_o   = (x_q <= SPEED_C);
    assign cross_o = (x_q > BIRD_C) && (x_moved <= BIRD_C);
    assign x_o     = x_q;
    assign top_o   = top_q;
    assign bot_o   = bot_q;

    // Next-state selection: load, move/recycle, or hold.
    always_comb begin
        x_d   = x_q;
        top_d = top_q;
        bot_d = bot_q;
        if (load_i) begin
            x_d   = X_INIT_C;
            top_d = rom_top_i;
            bot_d = rom_bot_i;
        end else if (move_i) begin
            if (recycle_i) begin
                x_d   = x_moved + RING_C;
                top_d = rom_top_i;
                bot_d = rom_bot_i;
            end else begin
                x_d   = x_moved;
            end
        end else begin
            x_d   = x_q;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q   <= {X_W{1'b0}};
            top_q <= {Y_W{1'b0}};
            bot_q <= {Y_W{1'b0}};
        end else begin
            x_q   <= x_d;
            top_q <= top_d;
            bot_q <= bot_d;
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Pipe scroller top: game FSM, ROM rotation index, score, and five pipe slots.
module pipe_scroller
    import game_pkg::*;
#(
    parameter int X_W     = 11,
    parameter int X_START = 680,
    parameter int SPACING = 200,
    parameter int SPEED   = 2,
    parameter int BIRD_X  = 160
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     game_over_i,
    input  logic                     tick_i,
    output logic [IDX_W-1:0]         rom_idx_o,
    input  logic [Y_W-1:0]           rom_top_i,
    input  logic [Y_W-1:0]           rom_bot_i,
    output logic [NUM_PIPES*X_W-1:0] pipe_x_o,
    output logic [NUM_PIPES*Y_W-1:0] pipe_top_o,
    output logic [NUM_PIPES*Y_W-1:0] pipe_bot_o,
    output logic                     running_o,
    output logic                     pass_o,
    output logic [7:0]               score_o
);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rom_idx_q, rom_idx_d;
    logic [IDX_W-1:0]       load_cnt_q, load_cnt_d;
    logic [7:0]             score_q, score_d;
    logic                   pass_q, pass_d;
    logic                   running_q, running_d;

    logic                   move_s;
    logic [NUM_PIPES-1:0]   load_vec_s, due_vec_s, cross_vec_s, recycle_vec_s;

    // A tick only moves the pipes in RUN when neither game_over nor start preempts it.
    assign move_s = (state_q == ST_RUN) && tick_i && !game_over_i && !start_i;

    // Lowest due slot wins the recycle; the others just subtract.
    assign recycle_vec_s = due_vec_s & (~due_vec_s + {{(NUM_PIPES-1){1'b0}}, 1'b1});

    genvar k;
    generate
        for (k = 0; k < NUM_PIPES; k++) begin : g_slot
            assign load_vec_s[k] = (state_q == ST_LOAD) && (load_cnt_q == IDX_W'(k));

            pipe_slot #(
                .X_W     (X_W),
                .X_INIT  (X_START + k * SPACING),
                .SPACING (SPACING),
                .SPEED   (SPEED),
                .BIRD_X  (BIRD_X)
            ) u_slot (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .load_i    (load_vec_s[k]),
                .move_i    (move_s),
                .recycle_i (recycle_vec_s[k]),
                .rom_top_i (rom_top_i),
                .rom_bot_i (rom_bot_i),
                .x_o       (pipe_x_o[k*X_W +: X_W]),
                .top_o     (pipe_top_o[k*Y_W +: Y_W]),
                .bot_o     (pipe_bot_o[k*Y_W +: Y_W]),
                .due_o     (due_vec_s[k]),
                .cross_o   (cross_vec_s[k])
            );
        end
    endgenerate

    // FSM next state plus rom index, load counter, score and pass pulse.
    always_comb begin
        state_d    = state_q;
        rom_idx_d  = rom_idx_q;
        load_cnt_d = load_cnt_q;
        score_d    = score_q;
        pass_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d    = ST_LOAD;
                    rom_idx_d  = {IDX_W{1'b0}};
                    load_cnt_d = {IDX_W{1'b0}};
                    score_d    = 8'd0;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_LOAD: begin
                rom_idx_d = idx_next(rom_idx_q);
                if (load_cnt_q == IDX_W'(NUM_PIPES - 1)) begin
                    state_d    = ST_RUN;
                    load_cnt_d = {IDX_W{1'b0}};
                end else begin
                    load_cnt_d = load_cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (game_over_i) begin
                    state_d = ST_HALT;
                end else if (start_i) begin
                    state_d    = ST_LOAD;
                    rom_idx_d  = {IDX_W{1'b0}};
                    load_cnt_d = {IDX_W{1'b0}};
                    score_d    = 8'd0;
                end else if (move_s) begin
                    if (|due_vec_s) begin
                        rom_idx_d = idx_next(rom_idx_q);
                    end else begin
                        rom_idx_d = rom_idx_q;
                    end
                    if (|cross_vec_s) begin
                        pass_d  = 1'b1;
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end else begin
                        pass_d  = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rom_idx_q  <= {IDX_W{1'b0}};
            load_cnt_q <= {IDX_W{1'b0}};
            score_q    <= 8'd0;
            pass_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_idx_q  <= rom_idx_d;
            load_cnt_q <= load_cnt_d;
            score_q    <= score_d;
            pass_q     <= pass_d;
            running_q  <= running_d;
        end
    end

    assign rom_idx_o = rom_idx_q;
    assign score_o   = score_q;
    assign pass_o    = pass_q;
    assign running_o = running_q;

endmodule
